// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared definitions for the parking-lot gate control and the password
// front-end: the gate state encoding, the served-side encoding and the
// default lot capacity / gate-open window.
// No ports (package only).
// -----------------------------------------------------------------------------
package parking_pkg;

    localparam int DEFAULT_CAPACITY    = 8;
    localparam int DEFAULT_OPEN_CYCLES = 16;
    localparam int OCC_W               = 4;
    localparam int TIMER_W             = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        OPEN_ENTRY = 2'd1,
        OPEN_EXIT  = 2'd2,
        CLOSE      = 2'd3
    } gate_state_t;

    typedef enum logic {
        SIDE_ENTRY = 1'b0,
        SIDE_EXIT  = 1'b1
    } gate_side_t;

    // True for either of the two barrier-open states.
    function automatic logic is_open_state(gate_state_t s);
        return (s == OPEN_ENTRY) || (s == OPEN_EXIT);
    endfunction

endpackage

// File: rtl/gate_timer.sv
// -----------------------------------------------------------------------------
// gate_timer
// Counts the cycles the barrier has been open. The count starts at 0 on the
// first open cycle and holds once it reaches OPEN_CYCLES-1, so it never wraps
// back into a small value while the window is still open.
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous active-high reset, clears the count
//   clear   - synchronous clear (has priority over en)
//   en      - advance the count by one
//   expired - high while the count equals OPEN_CYCLES-1
// -----------------------------------------------------------------------------
module gate_timer
    import parking_pkg::*;
#(
    parameter int OPEN_CYCLES = DEFAULT_OPEN_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(OPEN_CYCLES - 1);

    logic [TIMER_W-1:0] count;

    // Window counter: cleared outside the open states, advances while open.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != LAST_COUNT)) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expired = (count == LAST_COUNT);

endmodule

// File: rtl/parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// parking_gate_arbiter
// Arbitrates one shared barrier between the entrance and the exit of a car
// park, tracks the number of cars inside and flags open windows that expire
// without a car passing.
// Parameters:
//   CAPACITY    - maximum cars in the lot (1..15)
//   OPEN_CYCLES - gate-open window length in clock cycles (2..255)
// Ports:
//   clk           - rising-edge clock
//   reset         - asynchronous active-high reset
//   entry_req     - car waiting at the entrance sensor
//   entry_pass_ok - password accepted for the entrance car
//   exit_req      - car waiting at the exit sensor
//   car_cleared   - car has passed the barrier
//   entry_grant   - one-cycle pulse, barrier granted to the entrance
//   exit_grant    - one-cycle pulse, barrier granted to the exit
//   gate_open     - barrier drive
//   occupancy     - current car count
//   lot_full      - occupancy == CAPACITY
//   lot_empty     - occupancy == 0
//   timeout_err   - one-cycle pulse when the window expired with no car
// -----------------------------------------------------------------------------
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY    = DEFAULT_CAPACITY,
    parameter int OPEN_CYCLES = DEFAULT_OPEN_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             entry_pass_ok,
    input  logic             exit_req,
    input  logic             car_cleared,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic             gate_open,
    output logic [OCC_W-1:0] occupancy,
    output logic             lot_full,
    output logic             lot_empty,
    output logic             timeout_err
);

    localparam logic [OCC_W-1:0] CAP = OCC_W'(CAPACITY);

    gate_state_t      state;
    gate_side_t       last_served;
    logic             entry_ok;
    logic             exit_ok;
    logic             pick_exit;
    logic             timer_clear;
    logic             timer_en;
    logic             timer_expired;
    logic [OCC_W-1:0] occ_next;

    // Eligibility uses the registered full/empty flags; on a tie the side
    // that was not served last wins.
    assign entry_ok  = entry_req && entry_pass_ok && !lot_full;
    assign exit_ok   = exit_req && !lot_empty;
    assign pick_exit = exit_ok && (!entry_ok || (last_served == SIDE_ENTRY));

    // The window counter only runs in the open states, so it restarts from 0
    // on every new grant.
    assign timer_en    = is_open_state(state);
    assign timer_clear = !timer_en;

    gate_timer #(
        .OPEN_CYCLES (OPEN_CYCLES)
    ) u_gate_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // Next car count: only a cleared car in an open state moves it, and the
    // count saturates at both ends even though eligibility already keeps it
    // inside 0..CAPACITY.
    always_comb begin
        occ_next = occupancy;
        if ((state == OPEN_ENTRY) && car_cleared && (occupancy < CAP)) begin
            occ_next = occupancy + OCC_W'(1);
        end else if ((state == OPEN_EXIT) && car_cleared && (occupancy != '0)) begin
            occ_next = occupancy - OCC_W'(1);
        end
    end

    // Gate FSM with registered outputs. The full/empty flags are loaded from
    // the same next-count value as occupancy so the three always agree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_served <= SIDE_ENTRY;
            entry_grant <= 1'b0;
            exit_grant  <= 1'b0;
            gate_open   <= 1'b0;
            timeout_err <= 1'b0;
            occupancy   <= '0;
            lot_full    <= 1'b0;
            lot_empty   <= 1'b1;
        end else begin
            entry_grant <= 1'b0;
            exit_grant  <= 1'b0;
            timeout_err <= 1'b0;
            occupancy   <= occ_next;
            lot_full    <= (occ_next == CAP);
            lot_empty   <= (occ_next == '0);

            case (state)
                IDLE: begin
                    if (pick_exit) begin
                        state       <= OPEN_EXIT;
                        exit_grant  <= 1'b1;
                        gate_open   <= 1'b1;
                        last_served <= SIDE_EXIT;
                    end else if (entry_ok) begin
                        state       <= OPEN_ENTRY;
                        entry_grant <= 1'b1;
                        gate_open   <= 1'b1;
                        last_served <= SIDE_ENTRY;
                    end else begin
                        gate_open   <= 1'b0;
                    end
                end

                OPEN_ENTRY, OPEN_EXIT: begin
                    // A passing car beats an expiry seen in the same cycle.
                    if (car_cleared) begin
                        state     <= CLOSE;
                        gate_open <= 1'b0;
                    end else if (timer_expired) begin
                        state       <= CLOSE;
                        gate_open   <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end

                CLOSE: begin
                    state     <= IDLE;
                    gate_open <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    gate_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_arbiter
// Directed scoreboard bench. The stimulus process pushes the expected grant
// and gate-close events before driving each request; an independent monitor
// observes the DUT on the falling clock edge and pops/compares every event.
// -----------------------------------------------------------------------------
module tb_parking_gate_arbiter;

    localparam int CAPACITY    = 8;
    localparam int OPEN_CYCLES = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       entry_req;
    logic       entry_pass_ok;
    logic       exit_req;
    logic       car_cleared;
    logic       entry_grant;
    logic       exit_grant;
    logic       gate_open;
    logic [3:0] occupancy;
    logic       lot_full;
    logic       lot_empty;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    typedef enum int {EV_ENTRY_GRANT, EV_EXIT_GRANT, EV_CLOSE} ev_kind_t;

    typedef struct {
        ev_kind_t kind;
        int       occ;
        int       open_len;
        int       tmo;
        int       full;
        int       empty;
    } ev_t;

    ev_t expq[$];

    parking_gate_arbiter #(
        .CAPACITY    (CAPACITY),
        .OPEN_CYCLES (OPEN_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .entry_req     (entry_req),
        .entry_pass_ok (entry_pass_ok),
        .exit_req      (exit_req),
        .car_cleared   (car_cleared),
        .entry_grant   (entry_grant),
        .exit_grant    (exit_grant),
        .gate_open     (gate_open),
        .occupancy     (occupancy),
        .lot_full      (lot_full),
        .lot_empty     (lot_empty),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    // Immediate comparison used for static state (reset values, idle checks).
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected grant event: occupancy seen during the grant cycle.
    task automatic pushGrant(input ev_kind_t kind, input int occ);
        ev_t e;
        e.kind     = kind;
        e.occ      = occ;
        e.open_len = 0;
        e.tmo      = 0;
        e.full     = 0;
        e.empty    = 0;
        expq.push_back(e);
    endtask

    // Expected gate-close event: count after the window, how long the gate
    // stayed high, and whether the window timed out.
    task automatic pushClose(input int occ, input int open_len, input int tmo);
        ev_t e;
        e.kind     = EV_CLOSE;
        e.occ      = occ;
        e.open_len = open_len;
        e.tmo      = tmo;
        e.full     = (occ == CAPACITY) ? 1 : 0;
        e.empty    = (occ == 0) ? 1 : 0;
        expq.push_back(e);
    endtask

    // Compare one observed event against the head of the scoreboard.
    task automatic matchEvent(input ev_kind_t kind, input int len);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event: got kind %0d occ %0d, expected no event at %0t",
                     kind, occupancy, $time);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind || e.occ != int'(occupancy)) begin
                errors++;
                $display("[TB] FAIL event_kind_occ: got kind %0d occ %0d, expected kind %0d occ %0d at %0t",
                         kind, occupancy, e.kind, e.occ, $time);
            end else if (kind == EV_CLOSE &&
                         (e.open_len != len || e.tmo != int'(timeout_err) ||
                          e.full != int'(lot_full) || e.empty != int'(lot_empty))) begin
                errors++;
                $display("[TB] FAIL close_event: got len %0d tmo %0b full %0b empty %0b, expected len %0d tmo %0d full %0d empty %0d at %0t",
                         len, timeout_err, lot_full, lot_empty, e.open_len, e.tmo, e.full, e.empty, $time);
            end
        end
    endtask

    // Monitor: samples on the falling edge, reports grants and the cycle in
    // which the gate drops, and flags a timeout pulse anywhere else.
    initial begin : monitor
        int  open_len;
        bit  prev_gate;
        open_len  = 0;
        prev_gate = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                open_len  = 0;
                prev_gate = 1'b0;
            end else begin
                if (entry_grant) matchEvent(EV_ENTRY_GRANT, 0);
                if (exit_grant)  matchEvent(EV_EXIT_GRANT, 0);
                if (prev_gate && !gate_open) begin
                    matchEvent(EV_CLOSE, open_len);
                    open_len = 0;
                end else if (timeout_err) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL stray_timeout: got timeout_err 1 expected 0 at %0t", $time);
                end
                if (gate_open) open_len++;
                prev_gate = gate_open;
            end
        end
    end

    // Drive a request from IDLE, wait (bounded) for the grant, then assert
    // car_cleared on open cycle clear_cycle (0 means never, let it time out)
    // and return to IDLE.
    task automatic applyStimulus(input logic ent, input logic pass, input logic ext,
                                 input int clear_cycle);
        int lat;
        int n;
        lat           = 0;
        entry_req     = ent;
        entry_pass_ok = pass;
        exit_req      = ext;
        for (int i = 0; i < 8 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (entry_grant || exit_grant) lat = i + 1;
        end
        entry_req     = 1'b0;
        entry_pass_ok = 1'b0;
        exit_req      = 1'b0;
        if (lat == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_wait: got no grant within 8 cycles, expected a grant at %0t", $time);
        end else begin
            checkOutput("grant_latency", lat, 1);
            n = (clear_cycle == 0) ? OPEN_CYCLES : clear_cycle;
            for (int k = 1; k <= n; k++) begin
                if (k == clear_cycle) car_cleared = 1'b1;
                @(posedge clk);
                #1;
                car_cleared = 1'b0;
            end
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold a request that must not be granted; the monitor catches any grant.
    task automatic holdRequest(input logic ent, input logic pass, input logic ext, input int cycles);
        entry_req     = ent;
        entry_pass_ok = pass;
        exit_req      = ext;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        checkOutput("held_gate_open", int'(gate_open), 0);
        entry_req     = 1'b0;
        entry_pass_ok = 1'b0;
        exit_req      = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_gate_open"},   int'(gate_open),   0);
        checkOutput({tag, "_occupancy"},   int'(occupancy),   0);
        checkOutput({tag, "_lot_empty"},   int'(lot_empty),   1);
        checkOutput({tag, "_lot_full"},    int'(lot_full),    0);
        checkOutput({tag, "_grants"},      int'(entry_grant | exit_grant), 0);
        checkOutput({tag, "_timeout_err"}, int'(timeout_err), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin : stimulus
        int lat;
        reset         = 1'b1;
        entry_req     = 1'b0;
        entry_pass_ok = 1'b0;
        exit_req      = 1'b0;
        car_cleared   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetState("in_reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkResetState("after_reset");

        // Wrong password, and exit from an empty lot: neither is granted.
        $display("[TB] ineligible requests");
        holdRequest(1'b1, 1'b0, 1'b0, 4);
        holdRequest(1'b0, 1'b0, 1'b1, 4);
        checkOutput("empty_lot_empty", int'(lot_empty), 1);

        // First entry, car passes on open cycle 3.
        $display("[TB] first entry");
        pushGrant(EV_ENTRY_GRANT, 0);
        pushClose(1, 3, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3);
        checkOutput("first_entry_occ", int'(occupancy), 1);

        // Bring the count to 3.
        pushGrant(EV_ENTRY_GRANT, 1);
        pushClose(2, 1, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        pushGrant(EV_ENTRY_GRANT, 2);
        pushClose(3, 2, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 2);

        // Two ties in a row: exit first, then entry.
        $display("[TB] round-robin ties");
        pushGrant(EV_EXIT_GRANT, 3);
        pushClose(2, 2, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 2);
        pushGrant(EV_ENTRY_GRANT, 2);
        pushClose(3, 2, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 2);
        checkOutput("tie_final_occ", int'(occupancy), 3);

        // Window expires with no car.
        $display("[TB] timeout");
        pushGrant(EV_ENTRY_GRANT, 3);
        pushClose(3, OPEN_CYCLES, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        checkOutput("timeout_occ", int'(occupancy), 3);

        // Car passes on the very last open cycle: no timeout.
        $display("[TB] clear at expiry");
        pushGrant(EV_ENTRY_GRANT, 3);
        pushClose(4, OPEN_CYCLES, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, OPEN_CYCLES);

        // Fill the lot.
        $display("[TB] fill to capacity");
        for (int c = 1; c <= 4; c++) begin
            pushGrant(EV_ENTRY_GRANT, 3 + c);
            pushClose(4 + c, c, 0);
            applyStimulus(1'b1, 1'b1, 1'b0, c);
        end
        checkOutput("full_occ", int'(occupancy), 8);
        checkOutput("full_flag", int'(lot_full), 1);
        holdRequest(1'b1, 1'b1, 1'b0, 4);
        checkOutput("full_flag_held", int'(lot_full), 1);

        // One car leaves a full lot.
        pushGrant(EV_EXIT_GRANT, 8);
        pushClose(7, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput("after_exit_occ", int'(occupancy), 7);

        // car_cleared while idle changes nothing.
        car_cleared = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        car_cleared = 1'b0;
        checkOutput("idle_clear_occ", int'(occupancy), 7);

        // Down to 5 cars.
        pushGrant(EV_EXIT_GRANT, 7);
        pushClose(6, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        pushGrant(EV_EXIT_GRANT, 6);
        pushClose(5, 2, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2);

        // Reset in the middle of an exit window.
        $display("[TB] reset during open exit");
        pushGrant(EV_EXIT_GRANT, 5);
        exit_req = 1'b1;
        lat      = 0;
        for (int i = 0; i < 8 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (exit_grant) lat = i + 1;
        end
        exit_req = 1'b0;
        checkOutput("reset_test_grant_latency", lat, 1);
        checkOutput("reset_test_gate_before", int'(gate_open), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkResetState("mid_open_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkResetState("post_mid_reset");

        // Normal operation resumes after reset.
        pushGrant(EV_ENTRY_GRANT, 0);
        pushClose(1, 2, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 2);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_gate_arbiter.md
PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

Interface
- REQ-001 SHALL have parameter CAPACITY, default 8: maximum cars in the lot, range 1..15.
- REQ-002 SHALL have parameter OPEN_CYCLES, default 16: the gate-open window in clock cycles, range 2..255.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
- REQ-005 SHALL have port entry_req, input, 1 bit: a car is waiting at the entrance sensor.
- REQ-006 SHALL have port entry_pass_ok, input, 1 bit: the password check has passed for the entrance car.
- REQ-007 SHALL have port exit_req, input, 1 bit: a car is waiting at the exit sensor.
- REQ-008 SHALL have port car_cleared, input, 1 bit: the pass-through sensor reports that the car has cleared the barrier.
- REQ-009 SHALL have port entry_grant, output, 1 bit: one-cycle pulse when the barrier is granted to the entrance.
- REQ-010 SHALL have port exit_grant, output, 1 bit: one-cycle pulse when the barrier is granted to the exit.
- REQ-011 SHALL have port gate_open, output, 1 bit: drives the shared barrier.
- REQ-012 SHALL have port occupancy, output, 4 bits: current car count.
- REQ-013 SHALL have port lot_full, output, 1 bit: occupancy == CAPACITY.
- REQ-014 SHALL have port lot_empty, output, 1 bit: occupancy == 0.
- REQ-015 SHALL have port timeout_err, output, 1 bit: one-cycle pulse when the window expires with no car passing.

Function
- REQ-016 SHALL register all outputs; lot_full and lot_empty SHALL be derived from the registered occupancy.
- REQ-017 SHALL implement the states IDLE, OPEN_ENTRY, OPEN_EXIT and CLOSE.
- REQ-018 In IDLE, an entry request SHALL be eligible only when entry_req=1, entry_pass_ok=1 and lot_full=0.
- REQ-019 In IDLE, an exit request SHALL be eligible only when exit_req=1 and lot_empty=0.
- REQ-020 When both requests are eligible in the same cycle, the block SHALL grant the side not served last (round-robin); after reset, exit SHALL win the first tie.
- REQ-021 On the cycle after an eligible request is seen in IDLE, the block SHALL be in OPEN_x, with the matching grant=1 for exactly that cycle and gate_open=1 (latency 1).
- REQ-022 In OPEN_x, an open timer SHALL count from 0; car_cleared=1 SHALL move the block to CLOSE.
- REQ-023 On car_cleared in OPEN_x, occupancy SHALL update on the same edge: +1 for OPEN_ENTRY, -1 for OPEN_EXIT.
- REQ-024 If the timer reaches OPEN_CYCLES-1 with car_cleared=0, the block SHALL pulse timeout_err for one cycle, leave occupancy unchanged, and go to CLOSE.
- REQ-025 If car_cleared and the timer expiry occur in the same cycle, car_cleared SHALL take priority and timeout_err SHALL stay 0.
- REQ-026 In CLOSE, gate_open SHALL be 0 for exactly one cycle, and the state SHALL then return to IDLE, with no grant issued from CLOSE.
- REQ-027 Occupancy SHALL never exceed CAPACITY and never go below 0; the eligibility rules guarantee this, and saturation logic SHALL also be present.
- REQ-028 Requests and car_cleared SHALL be ignored outside the states where they are used, and car_cleared in IDLE SHALL have no effect.
- REQ-029 The last-served bit SHALL update only when a grant is issued.

Reset
- REQ-030 While reset=1, the block SHALL hold state=IDLE, occupancy=0, timer=0, last-served=entry (so that exit wins the first tie), all pulse outputs=0, gate_open=0, lot_empty=1 and lot_full=0.
- REQ-031 Reset asserted mid-OPEN SHALL close the gate immediately and asynchronously, and SHALL discard the pending occupancy update.

Structure
- REQ-032 The state encoding, the default CAPACITY and the default OPEN_CYCLES SHALL reside in shared package parking_pkg, which is reusable by the password front-end.
- REQ-033 The open-window counter SHALL be one sub-module, gate_timer, with ports clk, reset, clear, en and expired.

Verification
- REQ-034 After reset, drive entry_req=1 and entry_pass_ok=1, then car_cleared on the 3rd open cycle -> entry_grant pulses 1 cycle after the request; gate_open is high for 3 cycles, then low for 1 cycle; occupancy=1.
- REQ-035 With occupancy=3, drive entry (eligible) and exit_req in the same cycle twice in succession -> exit is granted first, then entry; final occupancy=3.
- REQ-036 Fill to occupancy=8, then drive entry_req=1 and entry_pass_ok=1 -> no grant, gate_open=0, lot_full=1; then an exit request -> occupancy=7.
- REQ-037 Grant an entry and never assert car_cleared -> timeout_err pulses in open cycle 16; occupancy unchanged; gate_open is 0 on the next cycle.
- REQ-038 Drive entry_req=1 with entry_pass_ok=0 -> no grant; with lot_empty=1, drive exit_req=1 -> no grant.
- REQ-039 Assert reset during OPEN_EXIT at occupancy=5 -> gate_open=0 within the reset cycle, occupancy=0, lot_empty=1.
